nonce_scheduler: RTL
====================

// Module: nonce_scheduler
// PURPOSE
//  Sequences one SHA-256d hash core for the FPGA miner. Accepts a job (header prefix + target),
//  sweeps the 32-bit nonce, starts the core once per nonce and compares each result to the target.
//  Reports winning nonces, exhaustion and core timeouts. Sits between the host/UART job loader
//  and the hash core; status feeds the LED and seven-segment display logic.
// PARAMETERS
//  HDR_W        608        header bits excluding the nonce
//  NONCE_START  32'h0      first nonce of the sweep (board partitioning)
//  NONCE_STEP   32'h1      nonce increment (number of boards sharing the range)
//  TIMEOUT      1024       max cycles from core_start to core_done before error
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  reset        in   1      asynchronous, active-low reset
//  job_valid    in   1      new job offered
//  job_ready    out  1      scheduler can accept a job (high only in IDLE)
//  job_header   in   HDR_W  header prefix, sampled on job handshake
//  job_target   in   256    target, unsigned, sampled on job handshake
//  abort        in   1      drop current job, return to IDLE
//  core_start   out  1      one-cycle start pulse to hash core
//  core_header  out  HDR_W  latched header to core
//  core_nonce   out  32     nonce to core; stable from start until done
//  core_done    in   1      one-cycle pulse, core_hash valid
//  core_hash    in   256    double-SHA result, numeric (already byte-reversed) order
//  found_valid  out  1      winning nonce available; held until found_ready
//  found_nonce  out  32     winning nonce
//  found_ready  in   1      consumer takes found_nonce
//  busy         out  1      state != IDLE
//  exhausted    out  1      sticky: sweep ended without further nonces; cleared on job accept
//  timeout_err  out  1      sticky: core missed TIMEOUT; cleared on job accept
//  hash_count   out  32     core_done count for current job, wraps mod 2^32
// BEHAVIOUR
//  Reset (reset=0): state IDLE, job_ready=1, all other outputs 0, registers 0; async assert, sync release.
//  FSM: IDLE -> ISSUE -> WAIT -> CHECK -> {ISSUE | FOUND | IDLE}; FOUND -> {ISSUE | IDLE}.
//  IDLE: job_valid&job_ready -> latch header/target, nonce=NONCE_START, clear exhausted,
//    timeout_err, hash_count; next ISSUE.
//  ISSUE: core_start=1 exactly one cycle, watchdog cleared; next WAIT.
//  WAIT: core_done -> latch core_hash, hash_count+1, next CHECK. Watchdog counts WAIT cycles;
//    reaching TIMEOUT without done -> timeout_err=1, next IDLE.
//  CHECK: hash <= target (256-bit unsigned) -> FOUND. Else last nonce -> exhausted=1, IDLE.
//    Else nonce += NONCE_STEP, ISSUE.
//  Last nonce: nonce > 32'hFFFFFFFF - NONCE_STEP (next add would overflow); nonce never wraps.
//  FOUND: found_valid=1, found_nonce=nonce; on found_ready -> found_valid=0 next cycle, then
//    continue as CHECK non-hit path (advance or exhaust).
//  Overhead per nonce: 2 cycles beyond core latency (ISSUE + CHECK).
//  abort: highest priority; any non-IDLE state -> IDLE next edge; core_start suppressed that
//    cycle; found_valid drops; sticky flags keep values. abort in IDLE: no effect.
//  core_done outside WAIT ignored (no count); job_valid outside IDLE ignored (job_ready=0).
//  core_done in the same cycle watchdog expires: done wins, no timeout.
// STRUCTURE
//  Shared header mining_defs.vh: NONCE_W=32, HASH_W=256, HDR_W default, FSM state encodings.
//  One sub-module: core_watchdog (clear/enable counter, expire flag at TIMEOUT).
//  Comparator and nonce adder inline.
// TESTING  (stub core: fixed 4-cycle latency, hash = {224'h0, nonce} ^ key)
//  1 Reset mid-WAIT -> all outputs 0, job_ready=1 same cycle, no core_start after release.
//  2 target=256'h0 hash always > target, NONCE_START=32'hFFFFFFFD, STEP=1 -> 3 core_starts,
//    nonces FFFFFFFD..FFFFFFFF, exhausted=1, hash_count=3, busy=0.
//  3 key chosen so nonce 5 hits, START=0 -> found_valid with found_nonce=5 after 6 starts;
//    hold found_ready=0 10 cycles -> no core_start; found_ready=1 -> next nonce 6 issued.
//  4 Stub never returns done, TIMEOUT=16 -> timeout_err=1 exactly 16 cycles after start, IDLE.
//  5 abort in ISSUE cycle -> core_start=0, IDLE next edge; late core_done ignored, count unchanged.
//  6 STEP=4, START=2 -> core_nonce sequence 2,6,10; spacing = latency 4 + 2 = 6 cycles.

Source files
------------

// File: rtl/nonce_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nonce_scheduler_pkg
// Purpose  : Shared widths, FSM state encoding and nonce-range helper for the
//            nonce scheduler and its watchdog.
// Revision : 1.0 - initial release
// ============================================================================
package nonce_scheduler_pkg;

    localparam int NONCE_W       = 32;
    localparam int HASH_W        = 256;
    localparam int HDR_W_DEFAULT = 608;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_FOUND = 3'd4
    } state_t;

    // True when adding step to nonce would overflow 32 bits, i.e. this nonce
    // is the final one of the sweep. The sweep never wraps around.
    function automatic logic is_last_nonce(input logic [NONCE_W-1:0] nonce,
                                           input logic [NONCE_W-1:0] step);
        return nonce > (32'hFFFF_FFFF - step);
    endfunction

endpackage : nonce_scheduler_pkg
`default_nettype wire

// File: rtl/nonce_scheduler_core_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : nonce_scheduler_core_watchdog
// Purpose  : Counts cycles spent waiting for the hash core and flags expiry
//            when TIMEOUT waiting cycles have elapsed without a result.
// Ports    : clk     - system clock
//            reset   - asynchronous active-low reset
//            clear   - zero the counter (asserted while the core is started)
//            enable  - count this cycle (asserted while waiting for done)
//            expired - high in the TIMEOUT-th enabled cycle after a clear
// Revision : 1.0 - initial release
// ============================================================================
module nonce_scheduler_core_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // The counter holds k-1 during the k-th waiting cycle, so expiry is
    // flagged during the TIMEOUT-th cycle; a done arriving in that same cycle
    // is still accepted by the scheduler.
    assign expired = enable && (r_count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : nonce_scheduler_core_watchdog
`default_nettype wire

// File: rtl/nonce_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : nonce_scheduler
// Purpose  : Sequences one SHA-256d core: accepts a job, sweeps the nonce,
//            starts the core once per nonce, compares each hash against the
//            target and reports winners, exhaustion and core timeouts.
// Ports    : clk, reset(active-low async)
//            job_valid/job_ready/job_header/job_target - job load handshake
//            abort                                     - drop current job
//            core_start/core_header/core_nonce         - to hash core
//            core_done/core_hash                       - from hash core
//            found_valid/found_nonce/found_ready       - winner handshake
//            busy, exhausted, timeout_err, hash_count  - status
// Revision : 1.0 - initial release
// ============================================================================
module nonce_scheduler
    import nonce_scheduler_pkg::*;
#(
    parameter int          HDR_W       = HDR_W_DEFAULT,
    parameter logic [31:0] NONCE_START = 32'h0,
    parameter logic [31:0] NONCE_STEP  = 32'h1,
    parameter int          TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [HDR_W-1:0]   job_header,
    input  logic [HASH_W-1:0]  job_target,
    input  logic               abort,
    output logic               core_start,
    output logic [HDR_W-1:0]   core_header,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_hash,
    output logic               found_valid,
    output logic [NONCE_W-1:0] found_nonce,
    input  logic               found_ready,
    output logic               busy,
    output logic               exhausted,
    output logic               timeout_err,
    output logic [31:0]        hash_count
);

    state_t              r_state;
    state_t              w_state_next;

    logic [HDR_W-1:0]    r_header;
    logic [HASH_W-1:0]   r_target;
    logic [HASH_W-1:0]   r_hash;
    logic [NONCE_W-1:0]  r_nonce;
    logic [31:0]         r_hash_count;
    logic                r_exhausted;
    logic                r_timeout_err;

    logic                w_accept;
    logic                w_capture;
    logic                w_advance;
    logic                w_exhaust;
    logic                w_timeout;
    logic                w_core_start;
    logic                w_hit;
    logic                w_last;
    logic                w_wd_expired;

    assign w_hit  = (r_hash <= r_target);
    assign w_last = is_last_nonce(r_nonce, NONCE_STEP);

    nonce_scheduler_core_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state == ST_ISSUE),
        .enable  (r_state == ST_WAIT),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle action strobes. Abort overrides everything
    // outside IDLE, including the start pulse of an ISSUE cycle.
    always_comb begin
        w_state_next = r_state;
        w_core_start = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_exhaust    = 1'b0;
        w_timeout    = 1'b0;
        if (abort && (r_state != ST_IDLE)) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (job_valid) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    w_core_start = 1'b1;
                    w_state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    // A done in the expiry cycle still counts as a result.
                    if (core_done) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_CHECK;
                    end else if (w_wd_expired) begin
                        w_timeout    = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (w_hit) begin
                        w_state_next = ST_FOUND;
                    end else if (w_last) begin
                        w_exhaust    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_ISSUE;
                    end
                end
                ST_FOUND: begin
                    // Once the winner is taken, carry on exactly as a miss.
                    if (found_ready) begin
                        if (w_last) begin
                            w_exhaust    = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_advance    = 1'b1;
                            w_state_next = ST_ISSUE;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_header      <= '0;
            r_target      <= '0;
            r_hash        <= '0;
            r_nonce       <= '0;
            r_hash_count  <= '0;
            r_exhausted   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_header      <= job_header;
                r_target      <= job_target;
                r_nonce       <= NONCE_START;
                r_hash_count  <= '0;
                r_exhausted   <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            if (w_capture) begin
                r_hash       <= core_hash;
                r_hash_count <= r_hash_count + 32'd1;
            end
            if (w_advance) begin
                r_nonce <= r_nonce + NONCE_STEP;
            end
            if (w_exhaust) begin
                r_exhausted <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign job_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign core_start  = w_core_start;
    assign core_header = r_header;
    assign core_nonce  = r_nonce;
    assign found_valid = (r_state == ST_FOUND);
    assign found_nonce = found_valid ? r_nonce : '0;
    assign exhausted   = r_exhausted;
    assign timeout_err = r_timeout_err;
    assign hash_count  = r_hash_count;

endmodule : nonce_scheduler
`default_nettype wire
